// File: rtl/regfile_param.sv
// Parametrised register file with phase-gated write window, N registered read ports and a sequential clear engine.
// Optional define REGFILE_BYPASS_EN forwards a committing write to same-address reads on the same edge.
module regfile_param #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int NRD         = 2,
  parameter int PHASES      = 1,
  parameter int WRITE_PHASE = 0,
  parameter int RESET_INDEX = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    regWrite,
  input  logic [ADDR_W-1:0]       writeReg,
  input  logic [DATA_W-1:0]       writeData,
  input  logic [NRD*ADDR_W-1:0]   readReg,
  output logic [NRD*DATA_W-1:0]   readData,
  input  logic                    clear,
  output logic                    busy,
  output logic [3:0]              phase
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [3:0]        PHASE_LAST = 4'(PHASES - 1);
  localparam logic [3:0]        WRITE_PH   = 4'(WRITE_PHASE);
  localparam logic [ADDR_W-1:0] IDX_FIRST  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST   = {ADDR_W{1'b1}};

  // Register 0 is never written, so its reset value of zero holds for good.
  function automatic logic [DATA_W-1:0] resetVal(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] v;
    if (RESET_INDEX != 0) begin
      v = DATA_W'(idx);
    end else begin
      v = '0;
    end
    return v;
  endfunction

  logic [DATA_W-1:0]     mem_r [DEPTH];
  logic [0:0]            state_r;
  logic                  busy_r;
  logic [ADDR_W-1:0]     sweepIdx_r;
  logic [3:0]            phase_r;
  logic [NRD*DATA_W-1:0] readData_r;

  logic                  commit_s;
  logic [ADDR_W-1:0]     rdAddr_s;
  logic [NRD*DATA_W-1:0] readNext_s;

  // Write qualification: request, open window, idle engine, non-zero address.
  always_comb begin
    commit_s = regWrite && (phase_r == WRITE_PH) && (state_r == IDLE) && (writeReg != '0);
  end

  // Read-port mux; forwarding only applies to a committing write.
  always_comb begin
    readNext_s = '0;
    rdAddr_s   = '0;
    for (int k = 0; k < NRD; k++) begin
      rdAddr_s = readReg[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      if (commit_s && (rdAddr_s == writeReg)) begin
        readNext_s[k*DATA_W +: DATA_W] = writeData;
      end else begin
        readNext_s[k*DATA_W +: DATA_W] = mem_r[rdAddr_s];
      end
`else
      readNext_s[k*DATA_W +: DATA_W] = mem_r[rdAddr_s];
`endif
    end
  end

  // Free-running phase counter, wraps at PHASES-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_r <= 4'd0;
    end else if (phase_r >= PHASE_LAST) begin
      phase_r <= 4'd0;
    end else begin
      phase_r <= phase_r + 4'd1;
    end
  end

  // Storage, write port and IDLE/CLEAR sweep engine.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      sweepIdx_r <= IDX_FIRST;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= resetVal(ADDR_W'(i));
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (commit_s) begin
            mem_r[writeReg] <= writeData;
          end
          if (clear) begin
            state_r    <= CLEAR;
            busy_r     <= 1'b1;
            sweepIdx_r <= IDX_FIRST;
          end
        end
        CLEAR: begin
          mem_r[sweepIdx_r] <= resetVal(sweepIdx_r);
          if (sweepIdx_r == IDX_LAST) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            sweepIdx_r <= IDX_FIRST;
          end else begin
            sweepIdx_r <= sweepIdx_r + ADDR_W'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          sweepIdx_r <= IDX_FIRST;
        end
      endcase
    end
  end

  // Registered read data, one-cycle latency in every state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readData_r <= '0;
    end else begin
      readData_r <= readNext_s;
    end
  end

  assign readData = readData_r;
  assign busy     = busy_r;
  assign phase    = phase_r;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: u0 with a write window every cycle, u1 with a 10-phase window open at phase 3.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        regWrite0 = 1'b0, clear0 = 1'b0, busy0;
  logic [4:0]  writeReg0 = 5'd0;
  logic [31:0] writeData0 = 32'd0;
  logic [9:0]  readReg0 = 10'd0;
  logic [63:0] readData0;
  logic [3:0]  phase0;

  logic        regWrite1 = 1'b0, clear1 = 1'b0, busy1;
  logic [4:0]  writeReg1 = 5'd0;
  logic [31:0] writeData1 = 32'd0;
  logic [9:0]  readReg1 = 10'd0;
  logic [63:0] readData1;
  logic [3:0]  phase1;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;
  int expPhase1 = 0;

  regfile_param u0 (
    .clock(clock), .reset(reset), .regWrite(regWrite0), .writeReg(writeReg0),
    .writeData(writeData0), .readReg(readReg0), .readData(readData0),
    .clear(clear0), .busy(busy0), .phase(phase0)
  );

  regfile_param #(.PHASES(10), .WRITE_PHASE(3)) u1 (
    .clock(clock), .reset(reset), .regWrite(regWrite1), .writeReg(writeReg1),
    .writeData(writeData1), .readReg(readReg1), .readData(readData1),
    .clear(clear1), .busy(busy1), .phase(phase1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) expPhase1 = (expPhase1 + 1) % 10;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit committed;
    bit commitNow;
    int n;

    // 1: reset values and index-valued registers
    #2;
    check("rst_rd0", readData0[31:0], 32'd0);
    check("rst_rd1", readData0[63:32], 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_phase0", {28'd0, phase0}, 32'd0);
    check("rst_phase1", {28'd0, phase1}, 32'd0);
    readReg0 = {5'd31, 5'd7};
    #10 reset = 1'b1;
    tick();
    check("init_r7", readData0[31:0], 32'd7);
    check("init_r31", readData0[63:32], 32'd31);
    check("init_phase0", {28'd0, phase0}, 32'd0);

    // 2: plain write, then dropped write to register 0
    regWrite0 = 1'b1; writeReg0 = 5'd5; writeData0 = 32'hDEADBEEF; readReg0 = {5'd0, 5'd5};
    tick();
    check("wr5_same", readData0[31:0], BYP ? 32'hDEADBEEF : 32'd5);
    regWrite0 = 1'b0;
    tick();
    check("wr5_next", readData0[31:0], 32'hDEADBEEF);
    regWrite0 = 1'b1; writeReg0 = 5'd0; writeData0 = 32'h1234; readReg0 = {5'd5, 5'd0};
    tick();
    regWrite0 = 1'b0;
    tick();
    check("wr0_drop", readData0[31:0], 32'd0);
    check("wr0_r5", readData0[63:32], 32'hDEADBEEF);

    // 3: phase-gated write on u1
    regWrite1 = 1'b1; writeReg1 = 5'd9; writeData1 = 32'hA5; readReg1 = {5'd0, 5'd9};
    committed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("ph_cnt", {28'd0, phase1}, 32'(expPhase1));
      commitNow = (expPhase1 == 3);
      tick();
      check("ph_rd9", readData1[31:0],
            (committed || (commitNow && BYP)) ? 32'hA5 : 32'd9);
      committed = committed | commitNow;
    end
    regWrite1 = 1'b0;
    tick();
    check("ph_final", readData1[31:0], 32'hA5);

    // 4: clear sweep with writes and clear held during busy
    regWrite0 = 1'b1; writeReg0 = 5'd12; writeData0 = 32'hFF;
    tick();
    regWrite0 = 1'b0; clear0 = 1'b1;
    tick();
    regWrite0 = 1'b1; writeReg0 = 5'd20; writeData0 = 32'h777;
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      tick();
    end
    regWrite0 = 1'b0; clear0 = 1'b0;
    check("clr_busy_len", 32'(n), 32'd31);
    readReg0 = {5'd20, 5'd12};
    tick();
    check("clr_r12", readData0[31:0], 32'd12);
    check("clr_r20", readData0[63:32], 32'd20);
    check("clr_idle", {31'd0, busy0}, 32'd0);

    // 5: reset mid-sweep
    regWrite0 = 1'b1; writeReg0 = 5'd7; writeData0 = 32'hBB;
    tick();
    writeReg0 = 5'd25; writeData0 = 32'hCC;
    tick();
    regWrite0 = 1'b0; clear0 = 1'b1;
    tick();
    clear0 = 1'b0;
    repeat (10) tick();
    check("mid_busy", {31'd0, busy0}, 32'd1);
    reset = 1'b0;
    expPhase1 = 0;
    #1;
    check("mid_rst_busy", {31'd0, busy0}, 32'd0);
    check("mid_rst_rd", readData0[31:0], 32'd0);
    check("mid_rst_ph1", {28'd0, phase1}, 32'd0);
    readReg0 = {5'd7, 5'd25};
    #3 reset = 1'b1;
    tick();
    check("mid_r25", readData0[31:0], 32'd25);
    check("mid_r7", readData0[63:32], 32'd7);
    check("mid_busy_after", {31'd0, busy0}, 32'd0);

    // 6: same-edge write/read, both ports on one address
    regWrite0 = 1'b1; writeReg0 = 5'd3; writeData0 = 32'h55; readReg0 = {5'd3, 5'd3};
    tick();
    regWrite0 = 1'b0;
    check("byp_p0", readData0[31:0], BYP ? 32'h55 : 32'd3);
    check("byp_p1", readData0[63:32], BYP ? 32'h55 : 32'd3);
    tick();
    check("byp_next_p0", readData0[31:0], 32'h55);
    check("byp_next_p1", readData0[63:32], 32'h55);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the single-cycle CPU register file.
- Configurable data width, depth and number of read ports.
- Programmable write-phase window for the multi-cycle datapath; a sequential clear engine restores initial contents without a global reset.
- Sits between the decode stage (read addresses) and the writeback mux (write port).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NRD, 2, number of read ports
PHASES, 1, phase counter modulus (1..16); 1 = write window every cycle
WRITE_PHASE, 0, phase value at which writes are accepted (< PHASES)
RESET_INDEX, 1, 1: register i resets/clears to value i; 0: all registers reset to 0

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
regWrite  in  1  write request
writeReg  in  ADDR_W  write address
writeData  in  DATA_W  write data
readReg  in  NRD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
readData  out  NRD*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W]
clear  in  1  start clear sweep (sampled in IDLE)
busy  out  1  high while clear sweep runs
phase  out  4  current phase counter value

Behaviour:
- Reset (reset==0, async):
  - register i = (RESET_INDEX ? i : 0); register 0 = 0
  - readData = 0, phase = 0, state = IDLE, busy = 0, sweep index = 1
- Phase counter:
  - increments every edge; wraps PHASES-1 -> 0
  - write window open when phase == WRITE_PHASE
- Write commit on a rising edge requires all of: regWrite==1, window open, state==IDLE, writeReg != 0.
  - Writes to address 0 are dropped.
  - Register 0 reads 0 always.
- Read:
  - every edge, readData[k] <= mem[readReg[k]] (pre-write contents); 1-cycle latency
  - reads run in all states, including CLEAR
- FSM IDLE / CLEAR:
  - IDLE -> CLEAR when clear==1; sweep index = 1, busy = 1 from the next cycle
  - CLEAR: each edge writes reset value into mem[index], index++
  - after index DEPTH-1 is written -> IDLE, busy = 0; sweep lasts DEPTH-1 cycles
  - clear==1 while in CLEAR is ignored (no restart)
  - regWrite during CLEAR is dropped silently; the phase counter keeps running
- Simultaneous clear + valid write in IDLE: write commits on that edge; the sweep later overwrites it.
- Reset during CLEAR: immediate IDLE, all registers restored, busy = 0.
- Multiple read ports addressing the same register return identical data.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: if a write commits on an edge and readReg[k] == writeReg (non-zero), readData[k] takes writeData on that same edge (write-through forwarding).
- Undefined: readData[k] returns the pre-write value; the new value is visible one read later.
- Address 0 is never forwarded in either case.

Test Plan:
1. reset=0 then release, RESET_INDEX=1; read ports at 7 and 31 -> readData = 7 and 31 one cycle later; busy=0, phase=0.
2. PHASES=1: write 0xDEADBEEF to reg 5, next cycle read reg 5 -> 0xDEADBEEF. Write 0x1234 to reg 0 -> reads 0.
3. PHASES=10, WRITE_PHASE=3: hold regWrite for 10 cycles writing 0xA5 to reg 9 -> commits only at phase 3; earlier reads of reg 9 return 9.
4. Write 0xFF to reg 12, pulse clear, issue writes during busy -> busy high exactly 31 cycles; afterwards reg 12 reads 12; writes issued while busy are absent.
5. Assert reset mid-sweep (cycle 10) -> busy drops at once; all registers read index values after release.
6. Same-edge write of 0x55 to reg 3 with readReg[0]=3 -> readData[0]=0x55 with REGFILE_BYPASS_EN, 3 without; next cycle 0x55 in both builds.
